// File: rtl/ex_stage.sv
// Execute stage: single-cycle R-type ALU with a registered result and
// write-back control, plus a 32-iteration shift-add multiplier that loads
// the internal HI/LO pair and holds off decode through in_ready while busy.
module ex_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [4:0]       writeReg,
    output logic             out_valid,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             regWriteOut,
    output logic [4:0]       writeRegOut,
    output logic             illegal
);

    localparam int CW = $clog2(MUL_CYCLES);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ok;
    logic               is_mul;
    logic               mul_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;

    assign accept = in_valid && in_ready;

    // Decode the function field into a result, a legality flag and a mult request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res    = '0;
        alu_ok     = 1'b1;
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        unique case (funct)
            F_ADD, F_ADDU: alu_res = readData1 + readData2;
            F_SUB, F_SUBU: alu_res = readData1 - readData2;
            F_AND:         alu_res = readData1 & readData2;
            F_OR:          alu_res = readData1 | readData2;
            F_XOR:         alu_res = readData1 ^ readData2;
            F_NOR:         alu_res = ~(readData1 | readData2);
            F_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(readData1) < $signed(readData2)};
            F_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, readData1 < readData2};
            F_MFHI:        alu_res = hi;
            F_MFLO:        alu_res = lo;
            F_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            F_MULTU:       is_mul = 1'b1;
            default:       alu_ok = 1'b0;
        endcase
    end

    // Operand magnitudes for the unsigned shift-add core; the most negative
    // value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag = (mul_signed && readData1[WIDTH-1]) ? -readData1 : readData1;
        b_mag = (mul_signed && readData2[WIDTH-1]) ? -readData2 : readData2;
    end

    // One shift-add step and the sign-corrected product for the final step.
    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
        product  = neg ? -acc_next : acc_next;
    end

    // Stage FSM, registered outputs and multiplier datapath.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            aluResult   <= '0;
            zero        <= 1'b0;
            regWriteOut <= 1'b0;
            writeRegOut <= '0;
            illegal     <= 1'b0;
            // NOTE: HI/LO are architectural state and are cleared on reset, so an aborted mult leaves no trace.
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
        end else begin
            out_valid   <= 1'b0;
            regWriteOut <= 1'b0;
            illegal     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mcand    <= {{WIDTH{1'b0}}, a_mag};
                            mplier   <= b_mag;
                            neg      <= mul_signed && (readData1[WIDTH-1] ^ readData2[WIDTH-1]);
                            acc      <= '0;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= MUL;
                        end else begin
                            out_valid   <= 1'b1;
                            aluResult   <= alu_res;
                            zero        <= (alu_res == '0);
                            regWriteOut <= alu_ok;
                            illegal     <= !alu_ok;
                            writeRegOut <= writeReg;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(MUL_CYCLES - 1)) begin
                        hi       <= product[2*WIDTH-1:WIDTH];
                        lo       <= product[WIDTH-1:0];
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected write-back results are queued as
// each instruction is issued and checked when out_valid appears.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] readData1, readData2;
    logic [4:0]  writeReg;
    logic        out_valid;
    logic [31:0] aluResult;
    logic        zero, regWriteOut, illegal;
    logic [4:0]  writeRegOut;

    typedef struct {
        logic [31:0] res;
        logic        regw;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .readData1(readData1), .readData2(readData2),
        .writeReg(writeReg), .out_valid(out_valid), .aluResult(aluResult),
        .zero(zero), .regWriteOut(regWriteOut), .writeRegOut(writeRegOut),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction; non-mult ops push their expected write-back.
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res,
                        input logic regw, input logic ill, input logic push);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        funct = f; readData1 = a; readData2 = b; writeReg = rd; in_valid = 1'b1;
        if (push) sb.push_back('{res: res, regw: regw, ill: ill, rd: rd});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("aluResult",   aluResult,   e.res);
                check("zero",        zero,        (e.res == 0));
                check("regWriteOut", regWriteOut, e.regw);
                check("illegal",     illegal,     e.ill);
                check("writeRegOut", writeRegOut, e.rd);
            end
        end
    end

    initial begin
        int low_cnt;
        rst = 1'b1; in_valid = 1'b0; funct = '0;
        readData1 = '0; readData2 = '0; writeReg = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",    in_ready,    1);
        check("rst_out_valid",   out_valid,   0);
        check("rst_aluResult",   aluResult,   0);
        check("rst_zero",        zero,        0);
        check("rst_regWriteOut", regWriteOut, 0);
        check("rst_writeRegOut", writeRegOut, 0);
        check("rst_illegal",     illegal,     0);
        rst = 1'b0;
        @(negedge clk);

        // add 5,7 -> 12, then the pulse must drop
        send(6'h20, 32'd5, 32'd7, 5'd9, 32'd12, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("add_pulse_drop", out_valid, 0);
        check("add_hold", aluResult, 32'd12);

        // back-to-back sub then nor
        send(6'h22, 32'd3, 32'd3, 5'd1, 32'd0, 1'b1, 1'b0, 1'b1);
        send(6'h27, 32'd0, 32'd0, 5'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);

        // comparisons and wrap-around
        send(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 1'b1, 1'b0, 1'b1);
        send(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd0, 1'b1, 1'b0, 1'b1);
        send(6'h21, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b1, 1'b0, 1'b1);
        send(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 32'h00F0_1200, 1'b1, 1'b0, 1'b1);
        send(6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 5'd7, 32'h5555_5555, 1'b1, 1'b0, 1'b1);

        // multu: 32 stalled cycles, no pulse, then read HI/LO
        send(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            low_cnt++;
        end
        check("multu_stall_cycles", low_cnt, 32);
        send(6'h10, 32'd0, 32'd0, 5'd10, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        send(6'h12, 32'd0, 32'd0, 5'd11, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);

        // signed mult -3 * 4 = -12
        send(6'h18, 32'hFFFF_FFFD, 32'd4, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(6'h10, 32'd0, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        send(6'h12, 32'd0, 32'd0, 5'd13, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b1);

        // reset mid-multiply aborts and clears HI/LO
        send(6'h18, 32'd7, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("mul_busy_before_rst", in_ready, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_mul_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(6'h12, 32'd0, 32'd0, 5'd14, 32'd0, 1'b1, 1'b0, 1'b1);
        send(6'h10, 32'd0, 32'd0, 5'd15, 32'd0, 1'b1, 1'b0, 1'b1);

        // unsupported funct
        send(6'h3F, 32'd1, 32'd2, 5'd16, 32'd0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the fetch/decode block (FEDE).
- Consumes `funct`, `readData1` and `readData2` for R-type instructions, plus the destination register number.
- Produces a registered ALU result and write-back control for the register bank.
- Contains a multi-cycle shift-add multiplier writing internal HI/LO registers, and stalls upstream through `in_ready` while the multiplier runs.

Parameters:
- WIDTH, 32, datapath width; the design is only required to be correct at 32.
- MUL_CYCLES, 32, iteration count of the multiplier; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decode presents a valid instruction this cycle
- in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready at a clk rising edge
- funct  input  6  R-type function field
- readData1  input  32  operand A (rs)
- readData2  input  32  operand B (rt)
- writeReg  input  5  destination register (rd)
- out_valid  output  1  one-cycle pulse: result fields are valid
- aluResult  output  32  registered result
- zero  output  1  aluResult == 0 (registered with aluResult)
- regWriteOut  output  1  write-back enable qualified by out_valid
- writeRegOut  output  5  destination register, registered
- illegal  output  1  one-cycle pulse with out_valid for an unsupported funct

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - state=IDLE, in_ready=1.
  - out_valid, aluResult, zero, regWriteOut, writeRegOut, illegal all 0.
  - HI=LO=0, multiplier counter=0.
- States: IDLE, MUL.
- IDLE:
  - in_ready=1.
  - Single-cycle op accepted at edge E: at E the outputs load, out_valid=1 for exactly one cycle.
  - Latency: 1 cycle, throughput 1 per cycle.
- Single-cycle ops (funct hex -> aluResult, regWriteOut=1):
  - 20 add: A+B, mod 2^32, no overflow trap.
  - 21 addu: A+B, mod 2^32.
  - 22 sub: A-B, mod 2^32.
  - 23 subu: A-B, mod 2^32.
  - 24 and: A&B.
  - 25 or: A|B.
  - 26 xor: A^B.
  - 27 nor: ~(A|B).
  - 2A slt: signed A<B ? 1 : 0.
  - 2B sltu: unsigned A<B ? 1 : 0.
  - 10 mfhi: HI.
  - 12 mflo: LO.
- mfhi/mflo read the HI/LO value current at the accepting edge.
- Cycles with no transfer: out_valid=0, regWriteOut=0, illegal=0; aluResult/zero/writeRegOut hold their last value.
- Unsupported funct: out_valid=1, illegal=1, aluResult=0, zero=1, regWriteOut=0.
- 18 mult (signed) / 19 multu (unsigned), accepted at edge E0:
  - At E0, latch the operand magnitudes (signed: absolute value; 0x80000000 -> magnitude 0x80000000) and the product sign (A[31]^B[31], signed only).
  - At E0, clear the 64-bit accumulator and counter; state -> MUL.
  - No out_valid at E0, and none at completion either.
  - MUL: in_ready=0. Each edge E1..E32 performs one shift-add iteration (counter 0..31).
  - At E32: HI:LO <= product (two's-complement negated if sign=1); state -> IDLE; in_ready=1 from E32 onward.
  - in_ready is low for exactly 32 cycles; the earliest next accept is E33.
  - in_valid during MUL is ignored; upstream holds its instruction.
- zero is always recomputed from the value loaded into aluResult.
- Reset asserted during MUL: abort, HI/LO cleared, state IDLE, no partial write.
- in_valid and rst together: reset wins.

Test Plan:
- Reset, then add 5,7 with writeReg=9 -> next cycle out_valid=1, aluResult=12, zero=0, regWriteOut=1, writeRegOut=9, then out_valid=0.
- Back-to-back sub 3,3 then nor 0,0 -> consecutive pulses: aluResult=0 with zero=1, then aluResult=0xFFFFFFFF with zero=0.
- slt 0xFFFFFFFF,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; addu 0xFFFFFFFF,1 -> 0 with zero=1.
- multu 0xFFFFFFFF,2 -> in_ready low for exactly 32 cycles, no out_valid; then mfhi -> 1 and mflo -> 0xFFFFFFFE.
- mult 0xFFFFFFFD(-3),4 -> mfhi=0xFFFFFFFF, mflo=0xFFFFFFF4.
- Reset asserted at iteration 10 of a mult -> in_ready=1 immediately and mflo returns 0.
- funct 0x3F -> illegal=1, regWriteOut=0, aluResult=0.
